regfile_wb_sched: RTL and testbench
===================================

// Module: regfile_wb_sched
// PURPOSE
//  Scoreboard and write-port scheduler for the 31-entry integer register file (x0 hard-wired zero).
//  Tracks which architectural registers have a pending write and stalls issue on RAW/WAW hazards.
//  Arbitrates the single regfile write port between the ALU and LSU writeback sources.
//  Sits between decode/issue, the execution units and regfile.
// PARAMETERS
//  XLEN    32  data width of the writeback path
//  AW      5   register address width; entries 1..2**AW-1 are tracked
//  CNT_W   16  width of the saturating stall-cycle counter
// PORTS
//  clk                     in   1     core clock
//  rst                     in   1     synchronous active-high reset
//  sched_i_flush           in   1     pipeline flush; clears scoreboard
//  sched_i_iss_valid       in   1     decode presents an instruction
//  sched_i_iss_rs1_addr    in   AW    source 1 (0 = unused/x0)
//  sched_i_iss_rs2_addr    in   AW    source 2 (0 = unused/x0)
//  sched_i_iss_rd_addr     in   AW    destination
//  sched_i_iss_rd_we       in   1     instruction writes rd
//  sched_o_iss_ready       out  1     issue may proceed this cycle
//  sched_i_alu_valid       in   1     ALU writeback request (source 0)
//  sched_i_alu_rd_addr     in   AW    ALU destination
//  sched_i_alu_rd_data     in   XLEN  ALU result
//  sched_o_alu_ready       out  1     ALU writeback accepted
//  sched_i_lsu_valid       in   1     LSU writeback request (source 1)
//  sched_i_lsu_rd_addr     in   AW    LSU destination
//  sched_i_lsu_rd_data     in   XLEN  load result
//  sched_o_lsu_ready       out  1     LSU writeback accepted
//  sched_o_rf_w_en         out  1     drives regfile write enable
//  sched_o_rf_rd_addr      out  AW    drives regfile write address
//  sched_o_rf_rd_data      out  XLEN  drives regfile write data
//  sched_o_busy            out  2**AW pending-write bit per register; bit 0 always 0
//  sched_o_stall_cnt       out  CNT_W cycles with iss_valid && !iss_ready, saturating
// BEHAVIOUR
//  Reset: busy=0, rr_last=1 (ALU wins first tie), stall_cnt=0. While rst is high: iss_ready=0, alu/lsu_ready=0, rf_w_en=0.
//  Hazard: haz = (rs1!=0 && busy[rs1]) | (rs2!=0 && busy[rs2]) | (rd_we && rd!=0 && busy[rd]).
//  iss_ready = !rst && !flush && !haz. Uses registered busy only; no same-cycle clear bypass.
//  Issue fire (iss_valid && iss_ready && rd_we && rd!=0): busy[rd] <= 1 at the next edge.
//  Arbitration (combinational, 0-cycle): one valid source is granted.
//    Both valid: grant the source not in rr_last; rr_last <= granted source on each grant.
//  The granted source's ready=1, and the non-granted source's ready=0.
//    rf_w_en = grant && rd!=0. rf_rd_addr/rf_rd_data are muxed from the granted source (0 when none).
//  Writeback to x0 is accepted (ready=1) and discarded; rf_w_en=0.
//  Writeback clear: busy[rd] <= 0 at the next edge for the granted rd. Clearing an idle bit is a no-op.
//  Set and clear of the same index in one cycle cannot occur, because WAW stalls issue.
//    If it occurs anyway, set wins.
//  Flush: all busy <= 0 next edge. Issue is blocked that cycle. Writebacks are still arbitrated and written normally.
//  Sources must hold valid/addr/data stable until ready. A source may drop valid only after acceptance.
//  stall_cnt increments when iss_valid && !iss_ready (flush included) and holds at 2**CNT_W-1.
//  Reset mid-operation: all state is cleared at the edge. In-flight writeback requests are dropped (ready=0).
// TESTING
//  1. Reset, then issue rd=5 rd_we=1 -> ready=1, next cycle busy[5]=1. An issue with rs1=5 -> ready=0, and stall_cnt increments.
//  2. ALU valid rd=5 data=0xDEADBEEF -> same cycle rf_w_en=1, addr=5, data=0xDEADBEEF, alu_ready=1; next cycle busy[5]=0 and the stalled issue fires.
//  3. ALU and LSU valid together for 3 cycles after reset -> grants ALU, LSU, ALU; the losing ready is 0 each cycle.
//  4. LSU writeback rd=0 -> lsu_ready=1, rf_w_en=0, busy unchanged. An issue with rs1=rs2=0 never stalls.
//  5. busy[3], busy[7] set; flush with iss_valid -> iss_ready=0 that cycle, busy=0 next cycle, and an ALU write to 7 in the same cycle still completes.
//  6. Hold a hazard for 2**CNT_W+5 cycles -> stall_cnt saturates at 0xFFFF. Assert rst mid-run -> busy=0, stall_cnt=0, all readies 0.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// rtl/regfile_wb_sched_if.sv - issue, writeback and regfile write-port bundle for the scheduler
interface regfile_wb_sched_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic              sched_i_flush;
  logic              sched_i_iss_valid;
  logic [AW-1:0]     sched_i_iss_rs1_addr;
  logic [AW-1:0]     sched_i_iss_rs2_addr;
  logic [AW-1:0]     sched_i_iss_rd_addr;
  logic              sched_i_iss_rd_we;
  logic              sched_o_iss_ready;
  logic              sched_i_alu_valid;
  logic [AW-1:0]     sched_i_alu_rd_addr;
  logic [XLEN-1:0]   sched_i_alu_rd_data;
  logic              sched_o_alu_ready;
  logic              sched_i_lsu_valid;
  logic [AW-1:0]     sched_i_lsu_rd_addr;
  logic [XLEN-1:0]   sched_i_lsu_rd_data;
  logic              sched_o_lsu_ready;
  logic              sched_o_rf_w_en;
  logic [AW-1:0]     sched_o_rf_rd_addr;
  logic [XLEN-1:0]   sched_o_rf_rd_data;
  logic [2**AW-1:0]  sched_o_busy;
  logic [CNT_W-1:0]  sched_o_stall_cnt;

  // Scheduler side
  modport slave (
    input  sched_i_flush, sched_i_iss_valid, sched_i_iss_rs1_addr, sched_i_iss_rs2_addr,
           sched_i_iss_rd_addr, sched_i_iss_rd_we,
           sched_i_alu_valid, sched_i_alu_rd_addr, sched_i_alu_rd_data,
           sched_i_lsu_valid, sched_i_lsu_rd_addr, sched_i_lsu_rd_data,
    output sched_o_iss_ready, sched_o_alu_ready, sched_o_lsu_ready,
           sched_o_rf_w_en, sched_o_rf_rd_addr, sched_o_rf_rd_data,
           sched_o_busy, sched_o_stall_cnt
  );

  // Decode / execution-unit / regfile side
  modport master (
    output sched_i_flush, sched_i_iss_valid, sched_i_iss_rs1_addr, sched_i_iss_rs2_addr,
           sched_i_iss_rd_addr, sched_i_iss_rd_we,
           sched_i_alu_valid, sched_i_alu_rd_addr, sched_i_alu_rd_data,
           sched_i_lsu_valid, sched_i_lsu_rd_addr, sched_i_lsu_rd_data,
    input  sched_o_iss_ready, sched_o_alu_ready, sched_o_lsu_ready,
           sched_o_rf_w_en, sched_o_rf_rd_addr, sched_o_rf_rd_data,
           sched_o_busy, sched_o_stall_cnt
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - register scoreboard, issue hazard stall and ALU/LSU writeback arbiter
module regfile_wb_sched #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_sched_if.slave  bus
);
  localparam int NREG = 2**AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_next;
  logic             rr_last;     // last granted source: 0 = ALU, 1 = LSU
  logic [CNT_W-1:0] stall_cnt;

  logic             haz;
  logic             iss_ready;
  logic             iss_fire;
  logic             grant_alu;
  logic             grant_lsu;
  logic             grant;
  logic [AW-1:0]    wb_addr;
  logic [XLEN-1:0]  wb_data;

  // RAW/WAW hazard against registered busy bits only; issue is also blocked in reset and flush
  always_comb begin
    haz = 1'b0;
    if (bus.sched_i_iss_rs1_addr != '0 && busy[bus.sched_i_iss_rs1_addr]) haz = 1'b1;
    if (bus.sched_i_iss_rs2_addr != '0 && busy[bus.sched_i_iss_rs2_addr]) haz = 1'b1;
    if (bus.sched_i_iss_rd_we && bus.sched_i_iss_rd_addr != '0 && busy[bus.sched_i_iss_rd_addr])
      haz = 1'b1;
    iss_ready = !rst && !bus.sched_i_flush && !haz;
    iss_fire  = bus.sched_i_iss_valid && iss_ready && bus.sched_i_iss_rd_we &&
                (bus.sched_i_iss_rd_addr != '0);
  end

  // Round-robin grant of the single regfile write port; the source not granted last wins a tie
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst) begin
      if (bus.sched_i_alu_valid && (!bus.sched_i_lsu_valid || rr_last)) grant_alu = 1'b1;
      else if (bus.sched_i_lsu_valid)                                  grant_lsu = 1'b1;
    end
    grant   = grant_alu | grant_lsu;
    wb_addr = '0;
    wb_data = '0;
    if (grant_alu) begin
      wb_addr = bus.sched_i_alu_rd_addr;
      wb_data = bus.sched_i_alu_rd_data;
    end else if (grant_lsu) begin
      wb_addr = bus.sched_i_lsu_rd_addr;
      wb_data = bus.sched_i_lsu_rd_data;
    end
  end

  // Next scoreboard: writeback clears, issue sets (set wins on a collision), flush clears all
  always_comb begin
    busy_next = busy;
    if (grant) busy_next[wb_addr] = 1'b0;
    if (iss_fire) busy_next[bus.sched_i_iss_rd_addr] = 1'b1;
    busy_next[0] = 1'b0;
    if (bus.sched_i_flush) busy_next = '0;
  end

  // State registers: scoreboard, round-robin pointer and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      rr_last   <= 1'b1;
      stall_cnt <= '0;
    end else begin
      busy <= busy_next;
      if (grant) rr_last <= grant_lsu;
      if (bus.sched_i_iss_valid && !iss_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.sched_o_iss_ready  = iss_ready;
  assign bus.sched_o_alu_ready  = grant_alu;
  assign bus.sched_o_lsu_ready  = grant_lsu;
  assign bus.sched_o_rf_w_en    = grant && (wb_addr != '0);
  assign bus.sched_o_rf_rd_addr = wb_addr;
  assign bus.sched_o_rf_rd_data = wb_data;
  assign bus.sched_o_busy       = busy;
  assign bus.sched_o_stall_cnt  = stall_cnt;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - self-checking bench for regfile_wb_sched
module tb_regfile_wb_sched;
  typedef struct {
    logic        src;   // 0 = ALU, 1 = LSU
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  wb_t  exp_q[$];

  regfile_wb_sched_if #(.XLEN(32), .AW(5), .CNT_W(16)) bus ();

  regfile_wb_sched #(.XLEN(32), .AW(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.sched_i_flush        = 1'b0;
    bus.sched_i_iss_valid    = 1'b0;
    bus.sched_i_iss_rs1_addr = '0;
    bus.sched_i_iss_rs2_addr = '0;
    bus.sched_i_iss_rd_addr  = '0;
    bus.sched_i_iss_rd_we    = 1'b0;
    bus.sched_i_alu_valid    = 1'b0;
    bus.sched_i_alu_rd_addr  = '0;
    bus.sched_i_alu_rd_data  = '0;
    bus.sched_i_lsu_valid    = 1'b0;
    bus.sched_i_lsu_rd_addr  = '0;
    bus.sched_i_lsu_rd_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive_issue(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic we);
    bus.sched_i_iss_valid    = 1'b1;
    bus.sched_i_iss_rs1_addr = rs1;
    bus.sched_i_iss_rs2_addr = rs2;
    bus.sched_i_iss_rd_addr  = rd;
    bus.sched_i_iss_rd_we    = we;
  endtask

  // Readies and write enable stay low while reset is held, state is clear afterwards
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    drive_issue(5'd0, 5'd0, 5'd1, 1'b1);
    bus.sched_i_alu_valid = 1'b1; bus.sched_i_alu_rd_addr = 5'd1;
    bus.sched_i_lsu_valid = 1'b1; bus.sched_i_lsu_rd_addr = 5'd2;
    @(negedge clk);
    checks++; if (bus.sched_o_iss_ready !== 1'b0) begin failures++; $display("FAIL reset_iss_ready got=%0b exp=0", bus.sched_o_iss_ready); end
    checks++; if (bus.sched_o_alu_ready !== 1'b0) begin failures++; $display("FAIL reset_alu_ready got=%0b exp=0", bus.sched_o_alu_ready); end
    checks++; if (bus.sched_o_lsu_ready !== 1'b0) begin failures++; $display("FAIL reset_lsu_ready got=%0b exp=0", bus.sched_o_lsu_ready); end
    checks++; if (bus.sched_o_rf_w_en !== 1'b0) begin failures++; $display("FAIL reset_rf_w_en got=%0b exp=0", bus.sched_o_rf_w_en); end
    step();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.sched_o_busy !== 32'h0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.sched_o_busy); end
    checks++; if (bus.sched_o_stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_stall_cnt got=%0h exp=0", bus.sched_o_stall_cnt); end
    step();
  endtask

  // RAW stall on a pending rd, cleared by an ALU writeback, then the stalled issue fires
  task automatic test_raw_stall();
    wb_t e;
    do_reset();
    drive_issue(5'd0, 5'd0, 5'd5, 1'b1);
    @(negedge clk);
    checks++; if (bus.sched_o_iss_ready !== 1'b1) begin failures++; $display("FAIL raw_first_issue_ready got=%0b exp=1", bus.sched_o_iss_ready); end
    step();
    drive_issue(5'd5, 5'd0, 5'd6, 1'b1);
    @(negedge clk);
    checks++; if (bus.sched_o_busy !== 32'h0000_0020) begin failures++; $display("FAIL raw_busy5 got=%0h exp=20", bus.sched_o_busy); end
    checks++; if (bus.sched_o_iss_ready !== 1'b0) begin failures++; $display("FAIL raw_stall_ready got=%0b exp=0", bus.sched_o_iss_ready); end
    step();
    checks++; if (bus.sched_o_stall_cnt !== 16'd1) begin failures++; $display("FAIL raw_stall_cnt1 got=%0d exp=1", bus.sched_o_stall_cnt); end
    bus.sched_i_alu_valid = 1'b1; bus.sched_i_alu_rd_addr = 5'd5; bus.sched_i_alu_rd_data = 32'hDEAD_BEEF;
    exp_q.push_back('{src: 1'b0, addr: 5'd5, data: 32'hDEAD_BEEF});
    @(negedge clk);
    checks++; if (bus.sched_o_iss_ready !== 1'b0) begin failures++; $display("FAIL raw_no_bypass got=%0b exp=0", bus.sched_o_iss_ready); end
    checks++; if (bus.sched_o_alu_ready !== 1'b1) begin failures++; $display("FAIL raw_alu_ready got=%0b exp=1", bus.sched_o_alu_ready); end
    checks++; if (bus.sched_o_rf_w_en !== 1'b1) begin failures++; $display("FAIL raw_rf_w_en got=%0b exp=1", bus.sched_o_rf_w_en); end
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL raw_sb_empty got=write exp=none"); end
    else begin
      e = exp_q.pop_front();
      checks++; if (bus.sched_o_rf_rd_addr !== e.addr) begin failures++; $display("FAIL raw_rf_addr got=%0d exp=%0d", bus.sched_o_rf_rd_addr, e.addr); end
      checks++; if (bus.sched_o_rf_rd_data !== e.data) begin failures++; $display("FAIL raw_rf_data got=%0h exp=%0h", bus.sched_o_rf_rd_data, e.data); end
    end
    step();
    bus.sched_i_alu_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.sched_o_busy !== 32'h0) begin failures++; $display("FAIL raw_busy_cleared got=%0h exp=0", bus.sched_o_busy); end
    checks++; if (bus.sched_o_iss_ready !== 1'b1) begin failures++; $display("FAIL raw_refire_ready got=%0b exp=1", bus.sched_o_iss_ready); end
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.sched_o_busy !== 32'h0000_0040) begin failures++; $display("FAIL raw_busy6 got=%0h exp=40", bus.sched_o_busy); end
    checks++; if (bus.sched_o_stall_cnt !== 16'd2) begin failures++; $display("FAIL raw_stall_cnt2 got=%0d exp=2", bus.sched_o_stall_cnt); end
    step();
  endtask

  // Both sources valid for three cycles after reset: ALU, LSU, ALU
  task automatic test_round_robin();
    wb_t e;
    do_reset();
    bus.sched_i_alu_valid = 1'b1; bus.sched_i_alu_rd_addr = 5'd1; bus.sched_i_alu_rd_data = 32'hA1A1_0001;
    bus.sched_i_lsu_valid = 1'b1; bus.sched_i_lsu_rd_addr = 5'd2; bus.sched_i_lsu_rd_data = 32'h1515_0002;
    exp_q.push_back('{src: 1'b0, addr: 5'd1, data: 32'hA1A1_0001});
    exp_q.push_back('{src: 1'b1, addr: 5'd2, data: 32'h1515_0002});
    exp_q.push_back('{src: 1'b0, addr: 5'd1, data: 32'hA1A1_0001});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL rr_sb_empty cycle=%0d", i); end
      else begin
        e = exp_q.pop_front();
        checks++; if (bus.sched_o_alu_ready !== !e.src) begin failures++; $display("FAIL rr_alu_ready cycle=%0d got=%0b exp=%0b", i, bus.sched_o_alu_ready, !e.src); end
        checks++; if (bus.sched_o_lsu_ready !== e.src) begin failures++; $display("FAIL rr_lsu_ready cycle=%0d got=%0b exp=%0b", i, bus.sched_o_lsu_ready, e.src); end
        checks++; if (bus.sched_o_rf_rd_addr !== e.addr) begin failures++; $display("FAIL rr_rf_addr cycle=%0d got=%0d exp=%0d", i, bus.sched_o_rf_rd_addr, e.addr); end
        checks++; if (bus.sched_o_rf_rd_data !== e.data) begin failures++; $display("FAIL rr_rf_data cycle=%0d got=%0h exp=%0h", i, bus.sched_o_rf_rd_data, e.data); end
        checks++; if (bus.sched_o_rf_w_en !== 1'b1) begin failures++; $display("FAIL rr_rf_w_en cycle=%0d got=%0b exp=1", i, bus.sched_o_rf_w_en); end
      end
      step();
    end
    clear_inputs();
  endtask

  // Writeback to x0 is accepted without a write; x0 sources never stall
  task automatic test_x0_writeback();
    do_reset();
    drive_issue(5'd0, 5'd0, 5'd9, 1'b1);
    step();
    clear_inputs();
    bus.sched_i_lsu_valid = 1'b1; bus.sched_i_lsu_rd_addr = 5'd0; bus.sched_i_lsu_rd_data = 32'h0000_1234;
    @(negedge clk);
    checks++; if (bus.sched_o_lsu_ready !== 1'b1) begin failures++; $display("FAIL x0_lsu_ready got=%0b exp=1", bus.sched_o_lsu_ready); end
    checks++; if (bus.sched_o_rf_w_en !== 1'b0) begin failures++; $display("FAIL x0_rf_w_en got=%0b exp=0", bus.sched_o_rf_w_en); end
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.sched_o_busy !== 32'h0000_0200) begin failures++; $display("FAIL x0_busy_kept got=%0h exp=200", bus.sched_o_busy); end
    step();
    for (int i = 0; i < 4; i++) begin
      drive_issue(5'd0, 5'd0, 5'd9, 1'b0);
      @(negedge clk);
      checks++; if (bus.sched_o_iss_ready !== 1'b1) begin failures++; $display("FAIL x0_src_ready cycle=%0d got=%0b exp=1", i, bus.sched_o_iss_ready); end
      step();
    end
    clear_inputs();
  endtask

  // Flush blocks issue, clears the scoreboard and still lets a writeback through
  task automatic test_flush();
    wb_t e;
    do_reset();
    drive_issue(5'd0, 5'd0, 5'd3, 1'b1);
    step();
    drive_issue(5'd0, 5'd0, 5'd7, 1'b1);
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.sched_o_busy !== 32'h0000_0088) begin failures++; $display("FAIL flush_busy_pre got=%0h exp=88", bus.sched_o_busy); end
    step();
    bus.sched_i_flush = 1'b1;
    drive_issue(5'd0, 5'd0, 5'd10, 1'b1);
    bus.sched_i_alu_valid = 1'b1; bus.sched_i_alu_rd_addr = 5'd7; bus.sched_i_alu_rd_data = 32'hCAFE_0007;
    exp_q.push_back('{src: 1'b0, addr: 5'd7, data: 32'hCAFE_0007});
    @(negedge clk);
    checks++; if (bus.sched_o_iss_ready !== 1'b0) begin failures++; $display("FAIL flush_iss_ready got=%0b exp=0", bus.sched_o_iss_ready); end
    checks++; if (bus.sched_o_alu_ready !== 1'b1) begin failures++; $display("FAIL flush_alu_ready got=%0b exp=1", bus.sched_o_alu_ready); end
    checks++; if (bus.sched_o_rf_w_en !== 1'b1) begin failures++; $display("FAIL flush_rf_w_en got=%0b exp=1", bus.sched_o_rf_w_en); end
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL flush_sb_empty got=write exp=none"); end
    else begin
      e = exp_q.pop_front();
      checks++; if (bus.sched_o_rf_rd_addr !== e.addr) begin failures++; $display("FAIL flush_rf_addr got=%0d exp=%0d", bus.sched_o_rf_rd_addr, e.addr); end
      checks++; if (bus.sched_o_rf_rd_data !== e.data) begin failures++; $display("FAIL flush_rf_data got=%0h exp=%0h", bus.sched_o_rf_rd_data, e.data); end
    end
    step();
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.sched_o_busy !== 32'h0) begin failures++; $display("FAIL flush_busy_post got=%0h exp=0", bus.sched_o_busy); end
    checks++; if (bus.sched_o_stall_cnt !== 16'd1) begin failures++; $display("FAIL flush_stall_cnt got=%0d exp=1", bus.sched_o_stall_cnt); end
    step();
  endtask

  // Long hazard saturates the stall counter; reset mid-run clears everything
  task automatic test_saturation();
    do_reset();
    drive_issue(5'd0, 5'd0, 5'd4, 1'b1);
    step();
    drive_issue(5'd4, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 65541; i++) begin
      step();
      if (i == 99) begin
        checks++; if (bus.sched_o_stall_cnt !== 16'd100) begin failures++; $display("FAIL sat_mid_count got=%0d exp=100", bus.sched_o_stall_cnt); end
      end
    end
    @(negedge clk);
    checks++; if (bus.sched_o_stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_stall_cnt got=%0h exp=ffff", bus.sched_o_stall_cnt); end
    checks++; if (bus.sched_o_busy !== 32'h0000_0010) begin failures++; $display("FAIL sat_busy4 got=%0h exp=10", bus.sched_o_busy); end
    step();
    rst = 1'b1;
    bus.sched_i_alu_valid = 1'b1; bus.sched_i_alu_rd_addr = 5'd4; bus.sched_i_alu_rd_data = 32'h4444_4444;
    bus.sched_i_lsu_valid = 1'b1; bus.sched_i_lsu_rd_addr = 5'd8; bus.sched_i_lsu_rd_data = 32'h8888_8888;
    @(negedge clk);
    checks++; if (bus.sched_o_iss_ready !== 1'b0) begin failures++; $display("FAIL midrst_iss_ready got=%0b exp=0", bus.sched_o_iss_ready); end
    checks++; if (bus.sched_o_alu_ready !== 1'b0) begin failures++; $display("FAIL midrst_alu_ready got=%0b exp=0", bus.sched_o_alu_ready); end
    checks++; if (bus.sched_o_lsu_ready !== 1'b0) begin failures++; $display("FAIL midrst_lsu_ready got=%0b exp=0", bus.sched_o_lsu_ready); end
    checks++; if (bus.sched_o_rf_w_en !== 1'b0) begin failures++; $display("FAIL midrst_rf_w_en got=%0b exp=0", bus.sched_o_rf_w_en); end
    step();
    @(negedge clk);
    checks++; if (bus.sched_o_busy !== 32'h0) begin failures++; $display("FAIL midrst_busy got=%0h exp=0", bus.sched_o_busy); end
    checks++; if (bus.sched_o_stall_cnt !== 16'h0) begin failures++; $display("FAIL midrst_stall_cnt got=%0h exp=0", bus.sched_o_stall_cnt); end
    step();
    clear_inputs();
    rst = 1'b0;
    step();
  endtask

  // Scenario sequence and summary
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    step();
    test_reset();
    test_raw_stall();
    test_round_robin();
    test_x0_writeback();
    test_flush();
    test_saturation();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
